pipeline_mem_arbiter: RTL

- Sequences the single-ported RAM between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Generates the ihit/dhit strobes that advance and freeze the pipeline latches.
- Data requests have priority; a bounded-starvation counter guarantees fetch progress.
- Sits between the pipeline stages and the RAM model, in the same clock domain.

---
 rtl/pipeline_mem_arbiter_pkg.sv | 14 +
 rtl/pipeline_mem_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared types for the pipeline memory arbiter: bus word and arbiter state encoding.
package pipeline_mem_arbiter_pkg;

    // All address and data buses between the pipeline and the RAM are one word wide.
    typedef logic [31:0] word_t;

    // Encoding 2'b11 is unused; the FSM steers it back to ARB_IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IACC = 2'd1,
        ARB_DACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Single-ported RAM arbiter between fetch (instruction reads) and memory stage
// (data reads/writes). Data wins by default; a saturating starvation counter
// forces an instruction grant after STARVE_LIMIT consecutive data grants issued
// while a fetch was waiting. Hits and RAM strobes are combinational from the
// state so an owner that drops its request aborts the access in the same cycle.
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 2,
    parameter int unsigned CW           = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iREN,
    input  word_t      iaddr,
    output logic       ihit,
    output word_t      iload,
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output logic       dhit,
    output word_t      dload,
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  logic       ramready,
    output logic [1:0] arb_state
);

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    arb_state_t    state;
    logic [CW-1:0] starve_cnt;
    logic          dreq;

    // Saturating increment of the starvation counter, pinned at LIMIT.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= LIMIT) ? LIMIT : v + CW'(1);
    endfunction

    assign dreq      = dREN | dWEN;
    assign arb_state = state;

    // Grant sequencing and starvation bookkeeping; every access returns to IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (dreq && ((starve_cnt < LIMIT) || !iREN)) begin
                        state <= ARB_DACC;
                        if (iREN) begin
                            starve_cnt <= sat_inc(starve_cnt);
                        end
                    end else if (iREN) begin
                        state      <= ARB_IACC;
                        starve_cnt <= '0;
                    end
                end
                ARB_IACC: begin
                    // Owner drop wins over a coincident ramready (abort, no hit).
                    if (!iREN || ramready) begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_DACC: begin
                    if (!dreq || ramready) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // RAM strobes, hits and load data decoded from state and the live request.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        case (state)
            ARB_IACC: begin
                ramaddr = iaddr;
                if (iREN) begin
                    ramREN = 1'b1;
                    ihit   = ramready;
                    iload  = ramready ? ramload : '0;
                end
            end
            ARB_DACC: begin
                ramaddr = daddr;
                // A write takes precedence when both data requests are raised.
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                    dhit     = ramready;
                end else if (dREN) begin
                    ramREN = 1'b1;
                    dhit   = ramready;
                    dload  = ramready ? ramload : '0;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
